// File: rtl/and_gate_checker_pkg.sv
// and_gate_checker_pkg
// Shared definitions for the AND-gate response monitor: the FSM state
// encoding, the input-combination indices ({input1,input2}) and the default
// width of the pass/fail counters.
package and_gate_checker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [1:0] C00 = 2'd0;
   localparam logic [1:0] C01 = 2'd1;
   localparam logic [1:0] C10 = 2'd2;
   localparam logic [1:0] C11 = 2'd3;

   localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/and_gate_checker_delay.sv
// and_check_delay
// LAT-stage shift register carrying {vld,a,b} from the stimulus side to the
// point where the gate output becomes valid. LAT=0 makes it a plain wire.
// Ports:
//   i_clk, i_rst      clock, async active-high reset
//   i_flush           synchronous flush of every stage
//   i_vld, i_a, i_b   sample entering the line
//   o_vld, o_a, o_b   sample leaving the line LAT cycles later
module and_check_delay
   import and_gate_checker_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_flush,
   input  logic i_vld,
   input  logic i_a,
   input  logic i_b,
   output logic o_vld,
   output logic o_a,
   output logic o_b
);

   generate
      if (LAT == 0) begin : g_wire
         assign {o_vld, o_a, o_b} = {i_vld, i_a, i_b};
      end else begin : g_pipe
         logic [LAT-1:0][2:0] r_pipe;

         always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
               r_pipe <= '0;
            end else if (i_flush) begin
               r_pipe <= '0;
            end else begin
               r_pipe[0] <= {i_vld, i_a, i_b};
               for (int s = 1; s < LAT; s++) begin
                  r_pipe[s] <= r_pipe[s-1];
               end
            end
         end

         assign {o_vld, o_a, o_b} = r_pipe[LAT-1];
      end
   endgenerate

endmodule

// File: rtl/and_gate_checker.sv
// and_gate_checker
// Response monitor for a two-input AND gate. Samples the stimulus pair on
// i_en, compares i_output1 LAT cycles later against the AND of that pair,
// counts passes/fails (saturating), tracks per-combination hits and latches
// the first mismatch.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_en                    stimulus pair valid this cycle
//   i_clear                 synchronous clear of all statistics, back to IDLE
//   i_input1, i_input2      gate inputs as driven by stimulus
//   i_output1               gate output under test
//   o_pass_cnt, o_fail_cnt  matching / mismatching checks
//   o_coverage              bit k: combination {input1,input2}=k checked
//   o_first_fail            {in1,in2,output1} of the first mismatch
//   o_first_fail_vld        o_first_fail holds a captured mismatch
//   o_done                  every combination reached MIN_HITS
//   o_error                 at least one mismatch seen
//
// state | meaning
// IDLE  | waiting for the first enabled sample
// RUN   | samples flowing, checks counted
// DONE  | coverage goal met, statistics frozen
module and_gate_checker
   import and_gate_checker_pkg::*;
#(
   parameter int LAT      = 1,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int HIT_W    = 4,
   parameter int MIN_HITS = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   input  logic             i_clear,
   input  logic             i_input1,
   input  logic             i_input2,
   input  logic             i_output1,
   output logic [CNT_W-1:0] o_pass_cnt,
   output logic [CNT_W-1:0] o_fail_cnt,
   output logic [3:0]       o_coverage,
   output logic [2:0]       o_first_fail,
   output logic             o_first_fail_vld,
   output logic             o_done,
   output logic             o_error
);

   localparam logic [HIT_W-1:0] LP_MIN_HITS = HIT_W'(MIN_HITS);
   localparam logic [HIT_W-1:0] LP_HIT_ONE  = HIT_W'(1);
   localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_pass_cnt;
   logic [CNT_W-1:0] r_fail_cnt;
   logic [HIT_W-1:0] r_hit [4];
   logic [2:0]       r_first_fail;
   logic             r_first_fail_vld;

   logic             w_dly_in_vld;
   logic             w_dly_vld;
   logic             w_dly_a;
   logic             w_dly_b;
   logic             w_check;
   logic             w_match;
   logic [1:0]       w_idx;
   logic             w_all_hit;

   // Once DONE the line keeps shifting but only carries bubbles, so
   // anything still in flight drains out unchecked.
   assign w_dly_in_vld = i_en & (r_state != DONE);

   and_check_delay #(
      .LAT (LAT)
   ) u_delay (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_flush (i_clear),
      .i_vld   (w_dly_in_vld),
      .i_a     (i_input1),
      .i_b     (i_input2),
      .o_vld   (w_dly_vld),
      .o_a     (w_dly_a),
      .o_b     (w_dly_b)
   );

   assign w_check = (r_state == RUN) & w_dly_vld;
   assign w_match = (i_output1 == (w_dly_a & w_dly_b));
   assign w_idx   = {w_dly_a, w_dly_b};

   always_comb begin
      w_all_hit = 1'b1;
      for (int k = 0; k < 4; k++) begin
         if (r_hit[k] < LP_MIN_HITS) begin
            w_all_hit = 1'b0;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (i_en)      w_state_nxt = RUN;
         RUN:     if (w_all_hit) w_state_nxt = DONE;
         DONE:    w_state_nxt = DONE;
         default: w_state_nxt = IDLE;
      endcase
      if (i_clear) begin
         w_state_nxt = IDLE;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_pass_cnt       <= '0;
         r_fail_cnt       <= '0;
         r_first_fail     <= '0;
         r_first_fail_vld <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            r_hit[k] <= '0;
         end
      end else if (i_clear) begin
         r_pass_cnt       <= '0;
         r_fail_cnt       <= '0;
         r_first_fail     <= '0;
         r_first_fail_vld <= 1'b0;
         for (int k = 0; k < 4; k++) begin
            r_hit[k] <= '0;
         end
      end else if (w_check) begin
         if (w_match) begin
            if (r_pass_cnt != '1) r_pass_cnt <= r_pass_cnt + LP_CNT_ONE;
         end else begin
            if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + LP_CNT_ONE;
            if (!r_first_fail_vld) begin
               r_first_fail     <= {w_dly_a, w_dly_b, i_output1};
               r_first_fail_vld <= 1'b1;
            end
         end
         if (r_hit[w_idx] != '1) r_hit[w_idx] <= r_hit[w_idx] + LP_HIT_ONE;
      end
   end

   // Hit counters saturate rather than wrap, so nonzero means "seen".
   always_comb begin
      o_coverage = '0;
      for (int k = 0; k < 4; k++) begin
         o_coverage[k] = (r_hit[k] != '0);
      end
   end

   assign o_pass_cnt       = r_pass_cnt;
   assign o_fail_cnt       = r_fail_cnt;
   assign o_first_fail     = r_first_fail;
   assign o_first_fail_vld = r_first_fail_vld;
   assign o_done           = (r_state == DONE);
   assign o_error          = (r_fail_cnt != '0);

endmodule

// File: tb/tb_and_gate_checker.sv
module tb_and_gate_checker;

   localparam int LAT_M    = 1;
   localparam int MIN_HITS = 2;
   localparam int M_IDLE   = 0;
   localparam int M_RUN    = 1;
   localparam int M_DONE   = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic in1 = 1'b0, in2 = 1'b0, force01 = 1'b0;
   logic en_m = 1'b0, clr_m = 1'b0;
   logic en_s = 1'b0, clr_s = 1'b0;
   logic en_l = 1'b0, clr_l = 1'b0;
   logic g1 = 1'b0, g2a = 1'b0, g2b = 1'b0;

   function automatic logic gate_fn(input logic a, input logic b, input logic f);
      return (a & b) | (f & ~a & b);
   endfunction

   // gate under test: one register for LAT=1, two for LAT=2
   always @(posedge clk) begin
      g1  <= gate_fn(in1, in2, force01);
      g2a <= gate_fn(in1, in2, force01);
      g2b <= g2a;
   end

   logic [15:0] pass_m, fail_m, pass_l, fail_l;
   logic [3:0]  pass_s, fail_s;
   logic [3:0]  cov_m, cov_s, cov_l;
   logic [2:0]  ff_m, ff_s, ff_l;
   logic        ffv_m, ffv_s, ffv_l, done_m, done_s, done_l, err_m, err_s, err_l;

   and_gate_checker #(.LAT(1), .CNT_W(16), .HIT_W(4), .MIN_HITS(MIN_HITS)) u_main (
      .i_clk(clk), .i_rst(rst), .i_en(en_m), .i_clear(clr_m),
      .i_input1(in1), .i_input2(in2), .i_output1(g1),
      .o_pass_cnt(pass_m), .o_fail_cnt(fail_m), .o_coverage(cov_m),
      .o_first_fail(ff_m), .o_first_fail_vld(ffv_m), .o_done(done_m), .o_error(err_m));

   and_gate_checker #(.LAT(1), .CNT_W(4), .HIT_W(4), .MIN_HITS(MIN_HITS)) u_sat (
      .i_clk(clk), .i_rst(rst), .i_en(en_s), .i_clear(clr_s),
      .i_input1(in1), .i_input2(in2), .i_output1(g1),
      .o_pass_cnt(pass_s), .o_fail_cnt(fail_s), .o_coverage(cov_s),
      .o_first_fail(ff_s), .o_first_fail_vld(ffv_s), .o_done(done_s), .o_error(err_s));

   and_gate_checker #(.LAT(2), .CNT_W(16), .HIT_W(4), .MIN_HITS(MIN_HITS)) u_lat2 (
      .i_clk(clk), .i_rst(rst), .i_en(en_l), .i_clear(clr_l),
      .i_input1(in1), .i_input2(in2), .i_output1(g2b),
      .o_pass_cnt(pass_l), .o_fail_cnt(fail_l), .o_coverage(cov_l),
      .o_first_fail(ff_l), .o_first_fail_vld(ffv_l), .o_done(done_l), .o_error(err_l));

   int n_vec = 0;
   int n_err = 0;

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // reference model: pending samples with the cycle at which they are judged
   typedef struct {
      int due;
      bit a;
      bit b;
      bit g;
   } smp_t;

   smp_t        m_q[$];
   int          m_st = M_IDLE;
   int          m_cyc = 0;
   int unsigned m_pass = 0, m_fail = 0;
   int          m_hit[4];
   bit          m_ffv = 1'b0;
   bit [2:0]    m_ff = 3'b000;

   task automatic model_reset();
      m_st   = M_IDLE;
      m_pass = 0;
      m_fail = 0;
      m_ffv  = 1'b0;
      m_ff   = 3'b000;
      for (int k = 0; k < 4; k++) m_hit[k] = 0;
      m_q.delete();
   endtask

   task automatic model_edge();
      bit   all_hit;
      smp_t e;
      int   idx;
      all_hit = 1'b1;
      for (int k = 0; k < 4; k++) if (m_hit[k] < MIN_HITS) all_hit = 1'b0;
      if (clr_m) begin
         model_reset();
      end else begin
         if (m_q.size() != 0 && m_q[0].due == m_cyc) begin
            e = m_q.pop_front();
            if (m_st == M_RUN) begin
               idx = 2 * int'(e.a) + int'(e.b);
               if (e.g == (e.a & e.b)) begin
                  if (m_pass < 65535) m_pass++;
               end else begin
                  if (m_fail < 65535) m_fail++;
                  if (!m_ffv) begin
                     m_ffv = 1'b1;
                     m_ff  = {e.a, e.b, e.g};
                  end
               end
               if (m_hit[idx] < 15) m_hit[idx]++;
            end
         end
         if (en_m && m_st != M_DONE) begin
            e.due = m_cyc + LAT_M;
            e.a   = in1;
            e.b   = in2;
            e.g   = gate_fn(in1, in2, force01);
            m_q.push_back(e);
         end
         if (m_st == M_IDLE && en_m) m_st = M_RUN;
         else if (m_st == M_RUN && all_hit) m_st = M_DONE;
      end
      m_cyc++;
   endtask

   task automatic check_main();
      logic [3:0] cov;
      for (int k = 0; k < 4; k++) cov[k] = (m_hit[k] != 0);
      chk_eq("pass_cnt", 32'(pass_m), m_pass);
      chk_eq("fail_cnt", 32'(fail_m), m_fail);
      chk_eq("coverage", 32'(cov_m), 32'(cov));
      chk_eq("done", 32'(done_m), 32'(m_st == M_DONE));
      chk_eq("error", 32'(err_m), 32'(m_fail != 0));
      chk_eq("first_fail_vld", 32'(ffv_m), 32'(m_ffv));
      chk_eq("first_fail", 32'(ff_m), 32'(m_ff));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_main();
   endtask

   task automatic clear_main();
      en_m  = 1'b0;
      clr_m = 1'b1;
      step();
      clr_m = 1'b0;
   endtask

   task automatic sweep(input bit f);
      for (int i = 0; i < 8; i++) begin
         {in1, in2} = 2'(i % 4);
         force01 = f;
         en_m    = 1'b1;
         step();
      end
      en_m = 1'b0;
      repeat (3) step();
      force01 = 1'b0;
   endtask

   initial begin
      logic [1:0] pat;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_main();
      chk_eq("rst_state", 32'(u_main.r_state), 32'd0);
      rst = 1'b0;
      step();

      // correct gate, full sweep twice
      sweep(1'b0);
      chk_eq("a_pass", 32'(pass_m), 32'd8);
      chk_eq("a_cov", 32'(cov_m), 32'hF);
      chk_eq("a_done", 32'(done_m), 32'd1);
      chk_eq("a_error", 32'(err_m), 32'd0);

      // gate stuck high on 01
      clear_main();
      sweep(1'b1);
      chk_eq("b_fail", 32'(fail_m), 32'd2);
      chk_eq("b_pass", 32'(pass_m), 32'd6);
      chk_eq("b_ff", 32'(ff_m), 32'b011);
      chk_eq("b_ffv", 32'(ffv_m), 32'd1);
      chk_eq("b_error", 32'(err_m), 32'd1);

      // only 00 and 11 for 100 cycles
      clear_main();
      for (int i = 0; i < 100; i++) begin
         pat = ($urandom_range(0, 1) != 0) ? 2'b11 : 2'b00;
         {in1, in2} = pat;
         en_m = 1'b1;
         step();
      end
      en_m = 1'b0;
      repeat (2) step();
      chk_eq("c_pass", 32'(pass_m), 32'd100);
      chk_eq("c_cov", 32'(cov_m), 32'b1001);
      chk_eq("c_done", 32'(done_m), 32'd0);
      clear_main();

      // 4-bit counters: 20 correct checks, 01 never driven
      for (int i = 0; i < 20; i++) begin
         case (i % 3)
            0: {in1, in2} = 2'b00;
            1: {in1, in2} = 2'b10;
            default: {in1, in2} = 2'b11;
         endcase
         en_s = 1'b1;
         step();
      end
      en_s = 1'b0;
      repeat (2) step();
      chk_eq("sat_pass", 32'(pass_s), 32'd15);
      chk_eq("sat_fail", 32'(fail_s), 32'd0);
      chk_eq("sat_cov", 32'(cov_s), 32'b1101);
      chk_eq("sat_done", 32'(done_s), 32'd0);

      // LAT=2: en 1,0,1,0
      {in1, in2} = 2'b11; en_l = 1'b1; step();
      en_l = 1'b0; step();
      {in1, in2} = 2'b10; en_l = 1'b1; step();
      en_l = 1'b0; step();
      chk_eq("l2_pass_mid", 32'(pass_l), 32'd1);
      step();
      chk_eq("l2_pass", 32'(pass_l), 32'd2);
      chk_eq("l2_fail", 32'(fail_l), 32'd0);
      chk_eq("l2_cov", 32'(cov_l), 32'b1100);
      {in1, in2} = 2'b11; en_l = 1'b1; clr_l = 1'b1; step();
      chk_eq("l2_clr_pass", 32'(pass_l), 32'd0);
      chk_eq("l2_clr_cov", 32'(cov_l), 32'd0);
      chk_eq("l2_clr_done", 32'(done_l), 32'd0);
      chk_eq("l2_clr_err", 32'(err_l), 32'd0);
      chk_eq("l2_clr_state", 32'(u_lat2.r_state), 32'd0);
      en_l = 1'b0; clr_l = 1'b0;
      repeat (3) step();
      chk_eq("l2_drop_pass", 32'(pass_l), 32'd0);
      chk_eq("l2_idle_state", 32'(u_lat2.r_state), 32'd0);

      // async reset after 3 checks
      clear_main();
      for (int i = 0; i < 4; i++) begin
         {in1, in2} = 2'(i);
         en_m = 1'b1;
         step();
      end
      chk_eq("e_pre_pass", 32'(pass_m), 32'd3);
      #2;
      rst  = 1'b1;
      en_m = 1'b0;
      #1;
      model_reset();
      check_main();
      chk_eq("e_rst_pass", 32'(pass_m), 32'd0);
      chk_eq("e_rst_cov", 32'(cov_m), 32'd0);
      #1;
      rst = 1'b0;
      step();
      sweep(1'b0);
      chk_eq("e_pass", 32'(pass_m), 32'd8);
      chk_eq("e_done", 32'(done_m), 32'd1);

      // random traffic with random faults and clears
      clear_main();
      for (int i = 0; i < 400; i++) begin
         en_m    = ($urandom_range(0, 3) != 0);
         in1     = 1'($urandom_range(0, 1));
         in2     = 1'($urandom_range(0, 1));
         force01 = ($urandom_range(0, 3) == 0);
         clr_m   = ($urandom_range(0, 24) == 0);
         step();
      end
      clr_m   = 1'b0;
      en_m    = 1'b0;
      force01 = 1'b0;
      repeat (3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
